dbg_uart_resp: RTL

//  Debug-bridge responder on the far side of the io_hub UART link. Consumes bytes from the

---
 rtl/dbg_uart_pkg.sv | 14 +
 rtl/dbg_uart_tx_seq.sv | 71 +++++++
 rtl/dbg_uart_resp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dbg_uart_pkg.sv
// Command/reply byte codes and FSM state types for the UART debug-bridge responder.
package dbg_uart_pkg;

   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_UNK = 8'h3F;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_TX} st_t;

   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO} tx_st_t;

endpackage

// File: rtl/dbg_uart_tx_seq.sv
// Reply byte sequencer: sends n_bytes of data MSB byte first, one transmit pulse per byte.
// Load-to-pulse 1 cycle; each byte waits for is_transmitting to rise and then fall.
module dbg_uart_tx_seq
   import dbg_uart_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = $clog2(DATA_W / 8 + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LEN_W-1:0]  n_bytes,
   input  logic [DATA_W-1:0] data,
   input  logic              is_transmitting,
   output logic              transmit,
   output logic [7:0]        tx_byte,
   output logic              done
);

   tx_st_t            st, st_nxt;
   logic [DATA_W-1:0] sh;
   logic [LEN_W-1:0]  left;
   logic              start;

   assign start   = load && (st == TX_IDLE) && !is_transmitting;
   assign tx_byte = sh[DATA_W-1 -: 8];

   always_ff @(posedge clk) begin
      if (rst) st <= TX_IDLE;
      else     st <= st_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh   <= '0;
         left <= '0;
      end else if (start) begin
         sh   <= data;
         left <= n_bytes;
      end else if (st == TX_WAIT_LO && !is_transmitting) begin
         sh   <= sh << 8;
         left <= left - LEN_W'(1);
      end
   end

   always_comb begin
      st_nxt   = st;
      transmit = 1'b0;
      done     = 1'b0;
      case (st)
         TX_IDLE:    if (start) st_nxt = TX_LOAD;
         TX_LOAD: begin
            transmit = 1'b1;
            st_nxt   = TX_WAIT_HI;
         end
         TX_WAIT_HI: if (is_transmitting) st_nxt = TX_WAIT_LO;
         TX_WAIT_LO: begin
            if (!is_transmitting) begin
               if (left == LEN_W'(1)) begin
                  done   = 1'b1;
                  st_nxt = TX_IDLE;
               end else begin
                  st_nxt = TX_LOAD;
               end
            end
         end
         default:    st_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/dbg_uart_resp.sv
// UART debug responder: parses R/W commands, runs one bus cycle, replies; bytes arriving mid-reply are dropped.
// Reply starts 2 cycles + bus latency after the last rx byte; DBG_UART_TIMEOUT_EN adds an inter-byte idle abort.
module dbg_uart_resp
   import dbg_uart_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              received,
   input  logic [7:0]        rx_byte,
   input  logic              recv_error,
   output logic              transmit,
   output logic [7:0]        tx_byte,
   input  logic              is_transmitting,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int ADDR_B = ADDR_W / 8;
   localparam int DATA_B = DATA_W / 8;
   localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
   localparam int CNT_W  = $clog2(MAX_B + 1);
   localparam int LEN_W  = $clog2(DATA_B + 1);
   localparam logic [DATA_W-9:0] PAD = '0;

   st_t               state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              is_wr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rsp_q;
   logic [LEN_W-1:0]  rsp_len;
   logic              rx_ok, last_addr, last_data, timeout, load, done;

   // recv_error overrides a simultaneous received pulse
   assign rx_ok     = received && !recv_error;
   assign last_addr = (cnt == CNT_W'(ADDR_B - 1));
   assign last_data = (cnt == CNT_W'(DATA_B - 1));

`ifdef DBG_UART_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (rst || received || !(state == S_ADDR || state == S_DATA)) idle_cnt <= '0;
      else                                                            idle_cnt <= idle_cnt + TO_W'(1);
   end

   assign timeout = (idle_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (recv_error)                                                   state_nxt = S_RESP;
            else if (rx_ok && (rx_byte == CMD_RD || rx_byte == CMD_WR))       state_nxt = S_ADDR;
            else if (rx_ok)                                                   state_nxt = S_RESP;
         end
         S_ADDR: begin
            if (recv_error)              state_nxt = S_RESP;
            else if (rx_ok && last_addr) state_nxt = is_wr ? S_DATA : S_BUS;
            else if (!rx_ok && timeout)  state_nxt = S_IDLE;
         end
         S_DATA: begin
            if (recv_error)              state_nxt = S_RESP;
            else if (rx_ok && last_data) state_nxt = S_BUS;
            else if (!rx_ok && timeout)  state_nxt = S_IDLE;
         end
         S_BUS:  if (bus_ack) state_nxt = S_RESP;
         S_RESP: begin
            if (!is_transmitting) begin
               load      = 1'b1;
               state_nxt = S_TX;
            end
         end
         S_TX:   if (done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         is_wr   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsp_q   <= '0;
         rsp_len <= '0;
      end else begin
         if (state_nxt != state)                             cnt <= '0;
         else if (rx_ok && (state == S_ADDR || state == S_DATA)) cnt <= cnt + CNT_W'(1);

         if (state == S_IDLE && rx_ok)  is_wr   <= (rx_byte == CMD_WR);
         if (state == S_ADDR && rx_ok)  addr_q  <= {addr_q[ADDR_W-9:0], rx_byte};
         if (state == S_DATA && rx_ok)  wdata_q <= {wdata_q[DATA_W-9:0], rx_byte};

         if (state_nxt == S_RESP && state != S_RESP) begin
            if (state == S_BUS) begin
               rsp_q   <= is_wr ? {RSP_OK, PAD} : bus_rdata;
               rsp_len <= is_wr ? LEN_W'(1) : LEN_W'(DATA_B);
            end else begin
               rsp_q   <= {(recv_error ? RSP_ERR : RSP_UNK), PAD};
               rsp_len <= LEN_W'(1);
            end
         end
      end
   end

   assign bus_req   = (state == S_BUS);
   assign bus_we    = is_wr;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

   dbg_uart_tx_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_tx_seq (
      .clk             (clk),
      .rst             (rst),
      .load            (load),
      .n_bytes         (rsp_len),
      .data            (rsp_q),
      .is_transmitting (is_transmitting),
      .transmit        (transmit),
      .tx_byte         (tx_byte),
      .done            (done)
   );

endmodule
